arm_exec_unit: RTL and testbench

- Execute stage of the 5-stage ARM-subset pipeline; sits between the ID/EX and EX/MEM pipeline registers.
- Selects forwarded operands and generates the second operand (Val2) from the immediate/shifter field.
- Runs the ALU and computes the branch target.
- Holds the NZCV status register, which supplies carry-in and is updated when the S bit is set.

---
 rtl/arm_exec_unit_pkg.sv | 51 +++++
 rtl/arm_exec_unit_if.sv | 48 ++++
 rtl/arm_alu_core.sv | 71 +++++++
 rtl/arm_val2_gen.sv | 62 ++++++
 rtl/arm_exec_unit.sv | 74 +++++++
 tb/tb_arm_exec_unit.sv | 190 +++++++++++++++++++
 6 files changed

// File: rtl/arm_exec_unit_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the ARM-subset execute stage: ALU command codes,
// shifter types, forwarding selects and NZCV bit positions, plus a small
// helper that resolves a forwarding select into an operand value.
// ---------------------------------------------------------------------------
package arm_pkg;

    // ALU operation codes carried in exe_cmd
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    // Immediate-shift types taken from shift_operand[6:5]
    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    // Forwarding selects; code 2'b11 also falls back to the register value
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Bit positions inside the {N,Z,C,V} nibble
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Pick the register value or one of the two bypassed results.
    function automatic logic [31:0] fwd_sel(input logic [1:0]  sel,
                                            input logic [31:0] regVal,
                                            input logic [31:0] memVal,
                                            input logic [31:0] wbVal);
        case (sel)
            FWD_MEM: fwd_sel = memVal;
            FWD_WB:  fwd_sel = wbVal;
            default: fwd_sel = regVal;
        endcase
    endfunction

endpackage

// File: rtl/arm_exec_unit_if.sv
// ---------------------------------------------------------------------------
// arm_exec_unit_if
// Bundles every datapath signal of the execute stage. The slave modport is
// the view of the execute unit itself (instruction fields in, results out);
// the master modport is the view of whoever feeds it (ID/EX side).
//   in : pc, val_rn, val_rm, alu_mem_val, wb_val, sel_src1, sel_src2,
//        exe_cmd, mem_r_en, mem_w_en, imm, s_update, shift_operand,
//        signed_imm_24
//   out: alu_result, br_addr, status, sr_q, val_rm_exec
// ---------------------------------------------------------------------------
interface arm_exec_unit_if #(parameter int WIDTH = 32);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] val_rn;
    logic [WIDTH-1:0] val_rm;
    logic [WIDTH-1:0] alu_mem_val;
    logic [WIDTH-1:0] wb_val;
    logic [1:0]       sel_src1;
    logic [1:0]       sel_src2;
    logic [3:0]       exe_cmd;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             imm;
    logic             s_update;
    logic [11:0]      shift_operand;
    logic [23:0]      signed_imm_24;

    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] br_addr;
    logic [3:0]       status;
    logic [3:0]       sr_q;
    logic [WIDTH-1:0] val_rm_exec;

    modport slave (
        input  pc, val_rn, val_rm, alu_mem_val, wb_val, sel_src1, sel_src2,
               exe_cmd, mem_r_en, mem_w_en, imm, s_update, shift_operand,
               signed_imm_24,
        output alu_result, br_addr, status, sr_q, val_rm_exec
    );

    modport master (
        output pc, val_rn, val_rm, alu_mem_val, wb_val, sel_src1, sel_src2,
               exe_cmd, mem_r_en, mem_w_en, imm, s_update, shift_operand,
               signed_imm_24,
        input  alu_result, br_addr, status, sr_q, val_rm_exec
    );

endinterface

// File: rtl/arm_alu_core.sv
// ---------------------------------------------------------------------------
// arm_alu_core
// Combinational ALU with NZCV generation.
//   a_i, b_i   operands (forwarded Rn and Val2)
//   cmd_i      exe_cmd operation code
//   c_i, v_i   current registered C and V (carry-in and held flags)
//   result_o   ALU result
//   status_o   {N,Z,C,V} for this operation
// ---------------------------------------------------------------------------
module arm_alu_core
    import arm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       cmd_i,
    input  logic             c_i,
    input  logic             v_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       status_o
);

    logic [WIDTH:0] sumWide;
    logic           carryOut;
    logic           ovfOut;

    // Arithmetic is done one bit wider so the carry out of the top bit falls
    // out of the sum. Subtraction is A + ~B + 1 (or + C for SBC), which makes
    // C mean "no borrow". Logical ops and unknown codes keep C and V.
    always_comb begin
        sumWide  = '0;
        result_o = '0;
        carryOut = c_i;
        ovfOut   = v_i;
        case (cmd_i)
            CMD_MOV: result_o = b_i;
            CMD_MVN: result_o = ~b_i;
            CMD_ADD, CMD_ADC: begin
                sumWide  = {1'b0, a_i} + {1'b0, b_i}
                         + {{WIDTH{1'b0}}, (cmd_i == CMD_ADC) & c_i};
                result_o = sumWide[WIDTH-1:0];
                carryOut = sumWide[WIDTH];
                ovfOut   = (a_i[WIDTH-1] == b_i[WIDTH-1])
                         && (result_o[WIDTH-1] != a_i[WIDTH-1]);
            end
            CMD_SUB, CMD_SBC: begin
                sumWide  = {1'b0, a_i} + {1'b0, ~b_i}
                         + {{WIDTH{1'b0}}, (cmd_i == CMD_SBC) ? c_i : 1'b1};
                result_o = sumWide[WIDTH-1:0];
                carryOut = sumWide[WIDTH];
                ovfOut   = (a_i[WIDTH-1] != b_i[WIDTH-1])
                         && (result_o[WIDTH-1] != a_i[WIDTH-1]);
            end
            CMD_AND: result_o = a_i & b_i;
            CMD_ORR: result_o = a_i | b_i;
            CMD_EOR: result_o = a_i ^ b_i;
            default: result_o = '0;
        endcase
    end

    // Pack the flags in NZCV order
    always_comb begin
        status_o         = '0;
        status_o[FLAG_N] = result_o[WIDTH-1];
        status_o[FLAG_Z] = (result_o == '0);
        status_o[FLAG_C] = carryOut;
        status_o[FLAG_V] = ovfOut;
    end

endmodule

// File: rtl/arm_val2_gen.sv
// ---------------------------------------------------------------------------
// arm_val2_gen
// Builds the ALU's second operand. Loads/stores use the raw 12-bit offset,
// data-processing immediates use the rotated 8-bit constant, and everything
// else uses the forwarded Rm passed through the immediate shifter.
//   rm_i            forwarded Rm value
//   shift_operand_i 12-bit shifter field
//   imm_i           I bit
//   mem_en_i        load or store in flight
//   val2_o          resulting operand
// ---------------------------------------------------------------------------
module arm_val2_gen
    import arm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rm_i,
    input  logic [11:0]      shift_operand_i,
    input  logic             imm_i,
    input  logic             mem_en_i,
    output logic [WIDTH-1:0] val2_o
);

    logic [4:0]         shiftAmt;
    logic [4:0]         rotAmt;
    logic [WIDTH-1:0]   immWord;
    logic [2*WIDTH-1:0] rotWide;
    logic               unused_regShiftBit;

    assign shiftAmt = shift_operand_i[11:7];
    assign rotAmt   = {shift_operand_i[11:8], 1'b0};
    assign immWord  = {{(WIDTH-8){1'b0}}, shift_operand_i[7:0]};

    // Bit 4 would select a register-specified shift, which this core does
    // not implement, so it is deliberately left out of the decode.
    assign unused_regShiftBit = shift_operand_i[4];

    // Operand selection. Rotates are done by shifting a doubled copy of the
    // word so that a rotate of zero needs no special case; LSL/LSR/ASR by
    // zero naturally leave Rm untouched.
    always_comb begin
        val2_o  = rm_i;
        rotWide = '0;
        if (mem_en_i) begin
            val2_o = {{(WIDTH-12){1'b0}}, shift_operand_i};
        end else if (imm_i) begin
            rotWide = {immWord, immWord} >> rotAmt;
            val2_o  = rotWide[WIDTH-1:0];
        end else begin
            case (shift_t'(shift_operand_i[6:5]))
                SH_LSL: val2_o = rm_i << shiftAmt;
                SH_LSR: val2_o = rm_i >> shiftAmt;
                SH_ASR: val2_o = $signed(rm_i) >>> shiftAmt;
                default: begin
                    rotWide = {rm_i, rm_i} >> shiftAmt;
                    val2_o  = rotWide[WIDTH-1:0];
                end
            endcase
        end
    end

endmodule

// File: rtl/arm_exec_unit.sv
// ---------------------------------------------------------------------------
// arm_exec_unit
// Execute stage of the 5-stage ARM-subset pipeline: operand forwarding,
// Val2 generation, ALU, branch target adder and the NZCV status register.
//   clk   rising edge updates the status register only
//   rst   asynchronous active-low reset of the status register
//   bus   arm_exec_unit_if.slave carrying instruction fields and results
// All outputs except sr_q are purely combinational.
// ---------------------------------------------------------------------------
module arm_exec_unit
    import arm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    arm_exec_unit_if.slave         bus
);

    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] rmF;
    logic [WIDTH-1:0] val2;
    logic [3:0]       statusNow;
    logic [3:0]       sr_q;
    logic [3:0]       sr_d;

    // Operand bypass from the MEM and WB stages
    assign op1 = fwd_sel(bus.sel_src1, bus.val_rn, bus.alu_mem_val, bus.wb_val);
    assign rmF = fwd_sel(bus.sel_src2, bus.val_rm, bus.alu_mem_val, bus.wb_val);

    arm_val2_gen #(.WIDTH(WIDTH)) u_val2 (
        .rm_i            (rmF),
        .shift_operand_i (bus.shift_operand),
        .imm_i           (bus.imm),
        .mem_en_i        (bus.mem_r_en | bus.mem_w_en),
        .val2_o          (val2)
    );

    arm_alu_core #(.WIDTH(WIDTH)) u_alu (
        .a_i      (op1),
        .b_i      (val2),
        .cmd_i    (bus.exe_cmd),
        .c_i      (sr_q[FLAG_C]),
        .v_i      (sr_q[FLAG_V]),
        .result_o (bus.alu_result),
        .status_o (statusNow)
    );

    // Branch target: word offset, sign-extended, relative to the carried PC
    assign bus.br_addr = bus.pc
                       + {{(WIDTH-26){bus.signed_imm_24[23]}}, bus.signed_imm_24, 2'b00};

    assign bus.status      = statusNow;
    assign bus.val_rm_exec = rmF;
    assign bus.sr_q        = sr_q;

    // Next status: capture the live flags only for S-bit instructions
    always_comb begin
        sr_d = sr_q;
        if (bus.s_update) begin
            sr_d = statusNow;
        end
    end

    // Status register; reset clears it immediately, without waiting for clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: tb/tb_arm_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_arm_exec_unit
// Directed vectors with hand-computed expectations. Each vector is driven
// just after a rising edge and its expected outputs are queued; a monitor
// on the falling edge pops the queue and compares every output.
// ---------------------------------------------------------------------------
module tb_arm_exec_unit;

    typedef struct {
        logic        rstN;
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [31:0] memv;
        logic [31:0] wbv;
        logic [1:0]  sel1;
        logic [1:0]  sel2;
        logic [3:0]  cmd;
        logic        memr;
        logic        memw;
        logic        immB;
        logic        sUpd;
        logic [11:0] so;
        logic [23:0] off;
    } stim_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [3:0]  st;
        logic [31:0] br;
        logic [31:0] rmx;
        logic [3:0]  sr;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    int    total = 0;
    int    bad = 0;
    exp_t  expQ[$];
    stim_t st;

    arm_exec_unit_if #(.WIDTH(32)) bus ();

    arm_exec_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Build a plain data-processing vector with everything else zeroed
    function automatic stim_t op(input logic [3:0] cmd, input logic [31:0] rn,
                                 input logic [31:0] rm, input logic immB,
                                 input logic [11:0] so, input logic sUpd);
        stim_t s;
        s      = '{rstN: 1'b1, pc: '0, rn: rn, rm: rm, memv: '0, wbv: '0,
                   sel1: 2'b00, sel2: 2'b00, cmd: cmd, memr: 1'b0, memw: 1'b0,
                   immB: immB, sUpd: sUpd, so: so, off: '0};
        return s;
    endfunction

    // Drive one vector after the rising edge and queue what it should give
    task automatic applyStimulus(input string name, input stim_t s,
                                 input logic [31:0] res, input logic [3:0] stv,
                                 input logic [31:0] br, input logic [31:0] rmx,
                                 input logic [3:0] sr);
        exp_t e;
        @(posedge clk);
        #1;
        rst               = s.rstN;
        bus.pc            = s.pc;
        bus.val_rn        = s.rn;
        bus.val_rm        = s.rm;
        bus.alu_mem_val   = s.memv;
        bus.wb_val        = s.wbv;
        bus.sel_src1      = s.sel1;
        bus.sel_src2      = s.sel2;
        bus.exe_cmd       = s.cmd;
        bus.mem_r_en      = s.memr;
        bus.mem_w_en      = s.memw;
        bus.imm           = s.immB;
        bus.s_update      = s.sUpd;
        bus.shift_operand = s.so;
        bus.signed_imm_24 = s.off;
        e = '{name: name, res: res, st: stv, br: br, rmx: rmx, sr: sr};
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input string field,
                               input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s.%s got=%h want=%h", name, field, act, want);
        end
    endtask

    // Monitor: compare live outputs against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e.name, "alu_result",  bus.alu_result,          e.res);
            checkOutput(e.name, "status",      {28'd0, bus.status},     {28'd0, e.st});
            checkOutput(e.name, "br_addr",     bus.br_addr,             e.br);
            checkOutput(e.name, "val_rm_exec", bus.val_rm_exec,         e.rmx);
            checkOutput(e.name, "sr_q",        {28'd0, bus.sr_q},       {28'd0, e.sr});
        end
    end

    initial begin
        st = op(4'h0, 32'h0, 32'h0, 1'b0, 12'h000, 1'b0);
        st.rstN = 1'b0;
        applyStimulus("reset",    st, 32'h0, 4'b0100, 32'h0, 32'h0, 4'b0000);

        st = op(4'b0010, 32'h7FFFFFFF, 32'h0, 1'b1, 12'h001, 1'b1);
        applyStimulus("adds",     st, 32'h80000000, 4'b1001, 32'h0, 32'h0, 4'b0000);
        st = op(4'b0100, 32'd5, 32'h0, 1'b1, 12'h005, 1'b1);
        applyStimulus("subs",     st, 32'h0, 4'b0110, 32'h0, 32'h0, 4'b1001);
        st = op(4'b0011, 32'd1, 32'h0, 1'b1, 12'h001, 1'b0);
        applyStimulus("adc",      st, 32'd3, 4'b0000, 32'h0, 32'h0, 4'b0110);

        st = op(4'b0001, 32'h0, 32'h80000001, 1'b0, 12'h0C0, 1'b0);
        applyStimulus("asr1",     st, 32'hC0000000, 4'b1010, 32'h0, 32'h80000001, 4'b0110);
        st = op(4'b0001, 32'h0, 32'h80000001, 1'b0, 12'h260, 1'b0);
        applyStimulus("ror4",     st, 32'h18000000, 4'b0010, 32'h0, 32'h80000001, 4'b0110);
        st = op(4'b0001, 32'h0, 32'h80000001, 1'b0, 12'h000, 1'b0);
        applyStimulus("lsl0",     st, 32'h80000001, 4'b1010, 32'h0, 32'h80000001, 4'b0110);
        st = op(4'b0001, 32'h0, 32'h80000001, 1'b1, 12'h4FF, 1'b0);
        applyStimulus("immrot",   st, 32'hFF000000, 4'b1010, 32'h0, 32'h80000001, 4'b0110);
        st = op(4'b0001, 32'h0, 32'h80000001, 1'b0, 12'h220, 1'b0);
        applyStimulus("lsr4",     st, 32'h08000000, 4'b0010, 32'h0, 32'h80000001, 4'b0110);

        st = op(4'b0100, 32'h55, 32'h66, 1'b0, 12'h000, 1'b0);
        st.sel1 = 2'b01; st.memv = 32'd10; st.sel2 = 2'b10; st.wbv = 32'd3;
        applyStimulus("fwd",      st, 32'd7, 4'b0010, 32'h0, 32'd3, 4'b0110);
        st = op(4'b0100, 32'd9, 32'd4, 1'b0, 12'h000, 1'b0);
        st.sel1 = 2'b11; st.memv = 32'd100; st.sel2 = 2'b11; st.wbv = 32'd200;
        applyStimulus("sel11",    st, 32'd5, 4'b0010, 32'h0, 32'd4, 4'b0110);

        st = op(4'b0010, 32'h100, 32'h12345678, 1'b0, 12'hFFF, 1'b0);
        st.memr = 1'b1;
        applyStimulus("memaddr",  st, 32'h10FF, 4'b0000, 32'h0, 32'h12345678, 4'b0110);
        st = op(4'b0010, 32'h0, 32'h0, 1'b1, 12'h4FF, 1'b0);
        st.memw = 1'b1;
        applyStimulus("memprio",  st, 32'h4FF, 4'b0000, 32'h0, 32'h0, 4'b0110);

        st = op(4'hF, 32'd7, 32'h0, 1'b1, 12'h001, 1'b0);
        applyStimulus("badcmd",   st, 32'h0, 4'b0110, 32'h0, 32'h0, 4'b0110);
        st = op(4'b1001, 32'h0, 32'h0, 1'b1, 12'h000, 1'b1);
        applyStimulus("mvns",     st, 32'hFFFFFFFF, 4'b1010, 32'h0, 32'h0, 4'b0110);

        st = op(4'b0111, 32'hF0, 32'h0, 1'b1, 12'h00F, 1'b0);
        st.pc = 32'h20; st.off = 24'hFFFFFE;
        applyStimulus("brback",   st, 32'hFF, 4'b0010, 32'h18, 32'h0, 4'b1010);
        st = op(4'b0110, 32'hF0, 32'h0, 1'b1, 12'h0FF, 1'b0);
        st.pc = 32'h1000; st.off = 24'h000010;
        applyStimulus("brfwd",    st, 32'hF0, 4'b0010, 32'h1040, 32'h0, 4'b1010);

        st = op(4'b0101, 32'd10, 32'h0, 1'b1, 12'h003, 1'b1);
        applyStimulus("sbcs_c1",  st, 32'd7, 4'b0010, 32'h0, 32'h0, 4'b1010);
        st = op(4'b0100, 32'd3, 32'h0, 1'b1, 12'h005, 1'b1);
        applyStimulus("subs_brw", st, 32'hFFFFFFFE, 4'b1000, 32'h0, 32'h0, 4'b0010);
        st = op(4'b0101, 32'd10, 32'h0, 1'b1, 12'h003, 1'b0);
        applyStimulus("sbc_c0",   st, 32'd6, 4'b0010, 32'h0, 32'h0, 4'b1000);
        st = op(4'b0010, 32'hFFFFFFFF, 32'h0, 1'b1, 12'h001, 1'b0);
        applyStimulus("addwrap",  st, 32'h0, 4'b0110, 32'h0, 32'h0, 4'b1000);
        st = op(4'h0, 32'h0, 32'h0, 1'b0, 12'h000, 1'b0);
        applyStimulus("hold",     st, 32'h0, 4'b0100, 32'h0, 32'h0, 4'b1000);

        st = op(4'h0, 32'h0, 32'h0, 1'b0, 12'h000, 1'b1);
        st.rstN = 1'b0;
        applyStimulus("asyncrst", st, 32'h0, 4'b0100, 32'h0, 32'h0, 4'b0000);

        for (int i = 0; i < 10 && expQ.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain pending=%0d want=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
